// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between instruction fetch and the data cache.
// Data has fixed priority, and a starvation guard forces the instruction side through.
// Defining MEM_ARB_STATS_EN adds saturating grant and conflict-cycle counters.
module mem_port_arbiter #(
   parameter int LATENCY      = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [15:0] stat_i_grants,
   output logic [15:0] stat_d_grants,
   output logic [15:0] stat_conflict_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, DONE} state_t;

   localparam logic [3:0] LAT_LOAD   = 4'(LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t     state;
   logic [3:0] lat_cnt;
   logic [3:0] starve_cnt;
   logic       grant_d;
   logic       grant_i;
   logic       last_cycle;

   // Data wins unless the instruction side has already waited through STARVE_LIMIT data grants.
   assign grant_d    = d_req && !(i_req && (starve_cnt == STARVE_MAX));
   assign grant_i    = !grant_d && i_req;
   assign last_cycle = (lat_cnt == 4'd0);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state      <= IDLE;
         lat_cnt    <= 4'd0;
         starve_cnt <= 4'd0;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         i_rdata    <= 32'd0;
         d_rdata    <= 32'd0;
      end else begin
         i_ready <= 1'b0;
         d_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state   <= ACC_D;
                  lat_cnt <= LAT_LOAD;
                  if (!i_req)
                     starve_cnt <= 4'd0;
                  else if (starve_cnt != STARVE_MAX)
                     starve_cnt <= starve_cnt + 4'd1;
               end else if (grant_i) begin
                  state      <= ACC_I;
                  lat_cnt    <= LAT_LOAD;
                  starve_cnt <= 4'd0;
               end
            end
            ACC_I: begin
               if (last_cycle) begin
                  i_rdata <= mem_rdata;
                  i_ready <= 1'b1;
                  state   <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            ACC_D: begin
               if (last_cycle) begin
                  if (!d_we)
                     d_rdata <= mem_rdata;
                  d_ready <= 1'b1;
                  state   <= DONE;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The memory side follows the granted requester combinationally; word-aligned by masking.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      case (state)
         ACC_I: begin
            mem_en   = 1'b1;
            mem_addr = i_addr & 32'hFFFF_FFFC;
         end
         ACC_D: begin
            mem_en    = 1'b1;
            mem_we    = d_we && last_cycle;
            mem_addr  = d_addr & 32'hFFFF_FFFC;
            mem_wdata = d_wdata;
         end
         default: ;
      endcase
   end

   assign busy = (state != IDLE);

`ifdef MEM_ARB_STATS_EN
   logic i_serviced;
   logic d_serviced;
   logic conflict;

   // A ready pulse marks the DONE cycle of that side, so it doubles as "still being serviced".
   assign i_serviced = (state == ACC_I) || i_ready || ((state == IDLE) && grant_i);
   assign d_serviced = (state == ACC_D) || d_ready || ((state == IDLE) && grant_d);
   assign conflict   = (i_req && !i_serviced) || (d_req && !d_serviced);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         stat_i_grants        <= 16'd0;
         stat_d_grants        <= 16'd0;
         stat_conflict_cycles <= 16'd0;
      end else begin
         if ((state == IDLE) && grant_i && (stat_i_grants != 16'hFFFF))
            stat_i_grants <= stat_i_grants + 16'd1;
         if ((state == IDLE) && grant_d && (stat_d_grants != 16'hFFFF))
            stat_d_grants <= stat_d_grants + 16'd1;
         if (conflict && (stat_conflict_cycles != 16'hFFFF))
            stat_conflict_cycles <= stat_conflict_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LATENCY=4, STARVE_LIMIT=4.
// Checks the statistics counters too when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] stat_i_grants;
   logic [15:0] stat_d_grants;
   logic [15:0] stat_conflict_cycles;
`endif

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.LATENCY(4), .STARVE_LIMIT(4)) dut (
      .CLK(CLK), .Reset(Reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
      , .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
      .stat_conflict_cycles(stat_conflict_cycles)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                                input logic [31:0] mr);
      i_req     = ir;
      i_addr    = ia;
      d_req     = dr;
      d_we      = dw;
      d_addr    = da;
      d_wdata   = dwd;
      mem_rdata = mr;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      repeat (2) nextCycle();
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
      checkOutput("rst_i_ready", {31'd0, i_ready}, 32'd0);
      checkOutput("rst_d_ready", {31'd0, d_ready}, 32'd0);
      checkOutput("rst_i_rdata", i_rdata, 32'd0);
      checkOutput("rst_d_rdata", d_rdata, 32'd0);
      Reset = 1'b0;
      nextCycle();

      // Single instruction read
      applyStimulus(1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'd0, 32'd0, 32'hE3A0_1005);
      checkOutput("i_c0_busy", {31'd0, busy}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         nextCycle();
         checkOutput("i_acc_en", {31'd0, mem_en}, 32'd1);
         checkOutput("i_acc_addr", mem_addr, 32'h0000_0104);
         checkOutput("i_acc_we", {31'd0, mem_we}, 32'd0);
         checkOutput("i_acc_rdy", {31'd0, i_ready}, 32'd0);
      end
      nextCycle();
      checkOutput("i_c5_ready", {31'd0, i_ready}, 32'd1);
      checkOutput("i_c5_rdata", i_rdata, 32'hE3A0_1005);
      checkOutput("i_c5_mem_en", {31'd0, mem_en}, 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      nextCycle();
      checkOutput("i_c6_busy", {31'd0, busy}, 32'd0);
      checkOutput("i_c6_ready", {31'd0, i_ready}, 32'd0);

      // Data write with unaligned address
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0203, 32'hDEAD_BEEF, 32'h1234_5678);
      for (int c = 1; c <= 4; c++) begin
         nextCycle();
         checkOutput("dw_addr", mem_addr, 32'h0000_0200);
         checkOutput("dw_we", {31'd0, mem_we}, (c == 4) ? 32'd1 : 32'd0);
      end
      checkOutput("dw_wdata", mem_wdata, 32'hDEAD_BEEF);
      nextCycle();
      checkOutput("dw_ready", {31'd0, d_ready}, 32'd1);
      checkOutput("dw_rdata", d_rdata, 32'd0);
      checkOutput("dw_i_ready", {31'd0, i_ready}, 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      nextCycle();

      // Simultaneous requests from a fresh reset: D first, then I
      Reset = 1'b1;
      nextCycle();
      Reset = 1'b0;
      applyStimulus(1'b1, 32'h0000_0110, 1'b1, 1'b0, 32'h0000_0220, 32'd0, 32'hA5A5_0001);
      nextCycle();
      checkOutput("sim_first_addr", mem_addr, 32'h0000_0220);
      repeat (4) nextCycle();
      checkOutput("sim_d_ready", {31'd0, d_ready}, 32'd1);
      checkOutput("sim_d_rdata", d_rdata, 32'hA5A5_0001);
      checkOutput("sim_i_ready5", {31'd0, i_ready}, 32'd0);
      applyStimulus(1'b1, 32'h0000_0110, 1'b0, 1'b0, 32'd0, 32'd0, 32'h5A5A_0002);
      nextCycle();
      checkOutput("sim_c6_busy", {31'd0, busy}, 32'd0);
      nextCycle();
      checkOutput("sim_c7_addr", mem_addr, 32'h0000_0110);
      repeat (3) nextCycle();
      checkOutput("sim_c10_rdy", {31'd0, i_ready}, 32'd0);
      nextCycle();
      checkOutput("sim_c11_rdy", {31'd0, i_ready}, 32'd1);
      checkOutput("sim_c11_rdata", i_rdata, 32'h5A5A_0002);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      nextCycle();
`ifdef MEM_ARB_STATS_EN
      checkOutput("stat_d", {16'd0, stat_d_grants}, 32'd1);
      checkOutput("stat_i", {16'd0, stat_i_grants}, 32'd1);
      checkOutput("stat_conf", {16'd0, stat_conflict_cycles}, 32'd6);
`endif

      // Starvation guard: four D grants, then I, then D again
      Reset = 1'b1;
      nextCycle();
      Reset = 1'b0;
      applyStimulus(1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 32'h0000_0077);
      for (int k = 1; k <= 6; k++) begin
         nextCycle();
         checkOutput($sformatf("starve_addr%0d", k), mem_addr,
                     (k == 5) ? 32'h0000_0400 : 32'h0000_0300);
         repeat (4) nextCycle();
         checkOutput($sformatf("starve_rdy%0d", k), {30'd0, i_ready, d_ready},
                     (k == 5) ? 32'd2 : 32'd1);
         nextCycle();
      end
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      repeat (6) nextCycle();

      // Reset in cycle 2 of an instruction access
      applyStimulus(1'b1, 32'h0000_0108, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0BAD_0BAD);
      nextCycle();
      checkOutput("rm_c1_en", {31'd0, mem_en}, 32'd1);
      nextCycle();
      Reset = 1'b1;
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0BAD_0BAD);
      nextCycle();
      Reset = 1'b0;
      checkOutput("rm_c3_busy", {31'd0, busy}, 32'd0);
      checkOutput("rm_c3_en", {31'd0, mem_en}, 32'd0);
      for (int c = 3; c <= 7; c++) begin
         checkOutput("rm_no_ready", {31'd0, i_ready}, 32'd0);
         nextCycle();
      end
      applyStimulus(1'b1, 32'h0000_010C, 1'b0, 1'b0, 32'd0, 32'd0, 32'hCAFE_0003);
      repeat (5) nextCycle();
      checkOutput("rm_new_ready", {31'd0, i_ready}, 32'd1);
      checkOutput("rm_new_rdata", i_rdata, 32'hCAFE_0003);
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
      nextCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
